rr_encoder_arbiter: RTL and testbench
=====================================

Name: rr_encoder_arbiter

Overview:
- Round-robin arbiter that shares the 8-input encode datapath between 8 requesters.
- Produces a registered one-hot grant and its 3-bit binary index, gated by a global enable.
- The index output drives the encoder select/output path directly. The block sits between requesting agents and the shared encoder stage.

Parameters:
HOLD_MAX, 16, max consecutive cycles one requester may hold a grant (used only when ARB_HOLD_LIMIT_EN is defined; range 2..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
EN  input  1  arbiter enable; low forces release and blocks new grants
req  input  8  request vector, one bit per requester, level-held until done
gnt  output  8  one-hot grant, registered
gnt_idx  output  3  binary index of gnt bit; 0 when no grant
gnt_valid  output  1  high while any gnt bit is set
ptr  output  3  current round-robin priority pointer (debug/observe)
hold_timeout  output  1  one-cycle pulse on forced release (tied 0 without macro)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, ptr=3'd0, hold_timeout=0, state=IDLE, hold counter=0.
- States: IDLE (no grant), GRANT (one requester owns the datapath).
- All outputs are registered. Latency is 1 cycle from the req/EN sample edge to gnt visible.

Winner search:
- Scan req from bit ptr upward, wrapping 7->0.
- The first set bit wins.
- Example: ptr=5, req=8'b0010_0011 -> winner 5. If req[5]=0, winner 0.

IDLE:
- If EN=1 and req!=0: go to GRANT, set gnt[w]=1, gnt_idx=w, gnt_valid=1, hold counter=1.
- Otherwise stay in IDLE with all outputs 0.

GRANT, winner w:
- req[w]=1 and EN=1: hold the grant; hold counter increments, saturating at 255.
- req[w]=0 and EN=1: release. ptr <= w+1 (mod 8, wraps 7->0).
  - If (req & ~(1<<w)) != 0, grant the next winner, searched from w+1, on the same edge. There is no idle bubble.
  - Otherwise go to IDLE.
- EN=0 (any req): next edge gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, ptr unchanged. EN has priority over every other event.

Invariants and edge cases:
- gnt is always one-hot or zero. gnt_idx is always the binary encoding of gnt.
- gnt_valid equals |gnt.
- A req bit that rises while another requester holds the grant is not granted until release.
- req=8'hFF held continuously with per-grant release gives grant order ptr, ptr+1, ... with wrap. No starvation: every requester is served within 8 grants.
- ptr changes only on release or timeout, never on EN-abort.
- Asynchronous reset mid-grant drops gnt immediately and restores ptr=0.

Optional Feature:
Macro: ARB_HOLD_LIMIT_EN
- Defined: in GRANT, if the hold counter reaches HOLD_MAX while req[w]=1 and EN=1:
  - Force release on that edge: ptr <= w+1, hold_timeout=1 for exactly one cycle.
  - The next winner is searched from w+1. w competes again at lowest priority if still requesting.
  - A sole requester is re-granted with no bubble and hold counter restarts at 1.
- Not defined: no hold limit, hold_timeout is constant 0, HOLD_MAX is ignored.

Test Plan:
- Reset with req=8'h00 -> gnt=0, gnt_idx=0, gnt_valid=0, ptr=0. Assert rst_n=0 mid-grant -> gnt=0 without waiting for a clock edge.
- EN=1, req=8'b0000_1000 at cycle 0 -> cycle 1: gnt=8'h08, gnt_idx=3, gnt_valid=1. Drop req[3] -> next edge gnt=0, ptr=4.
- ptr=0, req=8'hFF, each owner drops req for one cycle after 1 granted cycle -> gnt_idx sequence 0,1,2,...,7,0 with no idle cycles between grants.
- Grant held by 6 (ptr=6 before the grant), req=8'b0100_0001, EN dropped to 0 -> next edge gnt=0, ptr stays 6. EN=1 again -> gnt_idx=6.
- ptr=7, req=8'b0000_0110 -> gnt_idx=1 (wrap). Release -> gnt_idx=2, ptr=2.
- ARB_HOLD_LIMIT_EN, HOLD_MAX=4, req=8'b0001_0001 held, ptr=0:
  - gnt_idx=0 for 4 cycles, then hold_timeout pulses and gnt_idx=4, ptr=1.
  - Without the macro, gnt_idx stays 0 indefinitely.

Source files
------------

// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between the requesting agents and the round-robin encoder arbiter.
// The master side drives requests and enable; the slave (arbiter) side returns the grant.
interface rr_encoder_arbiter_if;
    localparam int unsigned NumReq = 8;
    localparam int unsigned IdxW   = 3;

    logic              EN;
    logic [NumReq-1:0] req;
    logic [NumReq-1:0] gnt;
    logic [IdxW-1:0]   gnt_idx;
    logic              gnt_valid;
    logic [IdxW-1:0]   ptr;
    logic              hold_timeout;

    modport master (
        output EN, req,
        input  gnt, gnt_idx, gnt_valid, ptr, hold_timeout
    );

    modport slave (
        input  EN, req,
        output gnt, gnt_idx, gnt_valid, ptr, hold_timeout
    );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter sharing the 8-input encode datapath among 8 requesters.
// Define ARB_HOLD_LIMIT_EN to force release after HOLD_MAX consecutive granted cycles.
module rr_encoder_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_encoder_arbiter_if.slave  bus
);
    localparam int unsigned NumReq = 8;
    localparam int unsigned IdxW   = 3;
    localparam int unsigned CntW   = 8;
    localparam logic [CntW-1:0] CntMax = '1;

    if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_range
        $error("rr_encoder_arbiter: HOLD_MAX must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     win_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     owner_nxt;
    logic [IdxW:0]       srch_ptr;
    logic [IdxW:0]       srch_nxt;

    // First set request at or after start, wrapping; returns {found, index}.
    function automatic logic [IdxW:0] rr_search(input logic [NumReq-1:0] r,
                                                input logic [IdxW-1:0]   start);
        logic [IdxW:0]   res;
        logic [IdxW-1:0] idx;
        res = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = start + IdxW'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign owner_nxt = idx_q + IdxW'(1);
    assign srch_ptr  = rr_search(bus.req, ptr_q);
    assign srch_nxt  = rr_search(bus.req, owner_nxt);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [CntW-1:0] HoldLim = CntW'(HOLD_MAX);
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state, next owner, pointer and hold counter. EN low overrides everything.
    always_comb begin : p_next
        state_d   = state_q;
        win_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.EN && srch_ptr[IdxW]) begin
                    state_d = GRANT;
                    win_d   = srch_ptr[IdxW-1:0];
                    cnt_d   = CntW'(1);
                end else begin
                    win_d = '0;
                    cnt_d = '0;
                end
            end
            GRANT: begin
                if (!bus.EN) begin
                    state_d = IDLE;
                    win_d   = '0;
                    cnt_d   = '0;
                end else if (bus.req[idx_q]) begin
`ifdef ARB_HOLD_LIMIT_EN
                    // Owner still requesting: it re-enters the search at lowest priority.
                    if (cnt_q >= HoldLim) begin
                        ptr_d     = owner_nxt;
                        win_d     = srch_nxt[IdxW-1:0];
                        cnt_d     = CntW'(1);
                        timeout_d = 1'b1;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
`else
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
`endif
                end else begin
                    ptr_d = owner_nxt;
                    if (srch_nxt[IdxW]) begin
                        win_d = srch_nxt[IdxW-1:0];
                        cnt_d = CntW'(1);
                    end else begin
                        state_d = IDLE;
                        win_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                win_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant encoding derived from the next owner.
    always_comb begin : p_out
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (state_d == GRANT) begin
            gnt_d[win_d] = 1'b1;
            idx_d        = win_d;
            valid_d      = 1'b1;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.gnt_idx      = idx_q;
    assign bus.gnt_valid    = valid_q;
    assign bus.ptr          = ptr_q;
    assign bus.hold_timeout = timeout_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Table-driven bench for rr_encoder_arbiter with a due-cycle scoreboard queue.
// Hold-limit expectations follow ARB_HOLD_LIMIT_EN.
module tb_rr_encoder_arbiter;
    localparam int unsigned HoldMax = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_encoder_arbiter_if bus();

    rr_encoder_arbiter #(.HOLD_MAX(HoldMax)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [2:0] idx;
        logic       vld;
        logic [2:0] ptr;
        logic       to;
    } vec_t;

    typedef struct {
        int         id;
        int         due;
        logic [2:0] idx;
        logic       vld;
        logic [2:0] ptr;
        logic       to;
    } exp_t;

    exp_t sb[$];
    vec_t main_tbl[$];
    vec_t hold_tbl[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic en, input logic [7:0] req, input logic [2:0] idx,
                                input logic vld, input logic [2:0] ptr, input logic to);
        vec_t v;
        v.en = en; v.req = req; v.idx = idx; v.vld = vld; v.ptr = ptr; v.to = to;
        return v;
    endfunction

    task automatic check(input int id, input logic [2:0] idx, input logic vld,
                         input logic [2:0] ptr, input logic to);
        logic [7:0] g;
        g = vld ? (8'h01 << idx) : 8'h00;
        n_vec++;
        if (bus.gnt !== g || bus.gnt_idx !== idx || bus.gnt_valid !== vld ||
            bus.ptr !== ptr || bus.hold_timeout !== to) begin
            n_miss++;
            $display("FAIL vec%0d: got gnt=%h idx=%0d vld=%b ptr=%0d to=%b, want gnt=%h idx=%0d vld=%b ptr=%0d to=%b",
                     id, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.ptr, bus.hold_timeout,
                     g, idx, vld, ptr, to);
        end
    endtask

    // Scoreboard: compare every expectation whose sampling edge has passed.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check(e.id, e.idx, e.vld, e.ptr, e.to);
        end
    end

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        @(posedge clk);
        #1;
        bus.EN  = v.en;
        bus.req = v.req;
        e.id = id; e.due = cyc + 1; e.idx = v.idx; e.vld = v.vld; e.ptr = v.ptr; e.to = v.to;
        sb.push_back(e);
    endtask

    task automatic drain(input int tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_vec++;
        if (sb.size() > 0) begin
            n_miss++;
            $display("FAIL drain%0d: got %0d pending expectations, want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // en, req, idx, vld, ptr, timeout (expected after the sampling edge)
        main_tbl.push_back(mk(1, 8'h08, 3, 1, 0, 0)); // single request
        main_tbl.push_back(mk(1, 8'h00, 0, 0, 4, 0)); // release -> ptr 4
        main_tbl.push_back(mk(1, 8'hFF, 4, 1, 4, 0)); // rotation under full load
        main_tbl.push_back(mk(1, 8'hEF, 5, 1, 5, 0));
        main_tbl.push_back(mk(1, 8'hDF, 6, 1, 6, 0));
        main_tbl.push_back(mk(1, 8'hBF, 7, 1, 7, 0));
        main_tbl.push_back(mk(1, 8'h7F, 0, 1, 0, 0));
        main_tbl.push_back(mk(1, 8'hFE, 1, 1, 1, 0));
        main_tbl.push_back(mk(1, 8'hFD, 2, 1, 2, 0));
        main_tbl.push_back(mk(1, 8'hFB, 3, 1, 3, 0));
        main_tbl.push_back(mk(1, 8'hF7, 4, 1, 4, 0));
        main_tbl.push_back(mk(1, 8'h00, 0, 0, 5, 0));
        main_tbl.push_back(mk(1, 8'h20, 5, 1, 5, 0));
        main_tbl.push_back(mk(1, 8'h41, 6, 1, 6, 0)); // owner 6 with ptr 6
        main_tbl.push_back(mk(1, 8'h41, 6, 1, 6, 0));
        main_tbl.push_back(mk(0, 8'h41, 0, 0, 6, 0)); // EN abort keeps ptr
        main_tbl.push_back(mk(0, 8'h41, 0, 0, 6, 0));
        main_tbl.push_back(mk(1, 8'h41, 6, 1, 6, 0));
        main_tbl.push_back(mk(1, 8'h00, 0, 0, 7, 0));
        main_tbl.push_back(mk(1, 8'h06, 1, 1, 7, 0)); // wrap search from 7
        main_tbl.push_back(mk(1, 8'h04, 2, 1, 2, 0));
        main_tbl.push_back(mk(1, 8'h00, 0, 0, 3, 0));
        main_tbl.push_back(mk(1, 8'h01, 0, 1, 3, 0));
        main_tbl.push_back(mk(1, 8'h09, 0, 1, 3, 0)); // late request waits
        main_tbl.push_back(mk(1, 8'h08, 3, 1, 1, 0));
        main_tbl.push_back(mk(1, 8'h00, 0, 0, 4, 0));
        main_tbl.push_back(mk(0, 8'hFF, 0, 0, 4, 0)); // EN low blocks grants
        main_tbl.push_back(mk(1, 8'h10, 4, 1, 4, 0));

`ifdef ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 4; i++) hold_tbl.push_back(mk(1, 8'h11, 0, 1, 0, 0));
        hold_tbl.push_back(mk(1, 8'h11, 4, 1, 1, 1));
        for (int i = 0; i < 3; i++) hold_tbl.push_back(mk(1, 8'h11, 4, 1, 1, 0));
        hold_tbl.push_back(mk(1, 8'h11, 0, 1, 5, 1));
        for (int i = 0; i < 3; i++) hold_tbl.push_back(mk(1, 8'h01, 0, 1, 5, 0));
        hold_tbl.push_back(mk(1, 8'h01, 0, 1, 1, 1)); // sole requester re-granted
        hold_tbl.push_back(mk(1, 8'h01, 0, 1, 1, 0));
`else
        for (int i = 0; i < 9; i++) hold_tbl.push_back(mk(1, 8'h11, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) hold_tbl.push_back(mk(1, 8'h01, 0, 1, 0, 0));
`endif

        bus.EN  = 1'b0;
        bus.req = 8'h00;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check(100, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < main_tbl.size(); i++) drive(main_tbl[i], i);
        drain(0);

        // Asynchronous reset while requester 4 holds the grant.
        rst_n   = 1'b0;
        bus.EN  = 1'b0;
        bus.req = 8'h00;
        #1;
        check(200, 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < hold_tbl.size(); i++) drive(hold_tbl[i], 300 + i);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
